// File: rtl/hash_pkg.sv
// Shared types and helpers for the hash round engine: FSM state encoding,
// initial-value lanes and the 8-bit rotate used by the lane round.
package hash_pkg;

    localparam int MAX_LANES = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ABSORB = 2'd1,
        FINAL  = 2'd2,
        OUT    = 2'd3
    } hash_state_e;

    function automatic logic [7:0] hash_iv(input int unsigned i);
        logic [7:0] idx;
        idx = i[7:0];
        return 8'h5A ^ idx;
    endfunction

    // Rotate left by s: the upper byte of the doubled word shifted left.
    function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] s);
        logic [15:0] dbl;
        dbl = {x, x} << s;
        return dbl[15:8];
    endfunction

endpackage

// File: rtl/hash_lane_round.sv
// Combinational hash round R(h, M): every lane mixes its neighbour lane with
// the round byte, rotates by its lane index and passes through the AES S-box.
module aes_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[x];

endmodule

module hash_lane_round #(
    parameter int N_LANES = 8
) (
    input  logic [N_LANES*8-1:0] h_in,
    input  logic [7:0]           m,
    output logic [N_LANES*8-1:0] h_out
);

    import hash_pkg::*;

    // All lanes read the pre-round state, so the round has no lane-to-lane chain.
    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        logic [7:0] mixed;

        assign mixed = rotl8(h_in[((i + 1) % N_LANES)*8 +: 8] ^ m, 3'(i % 8));

        aes_sbox u_sbox (
            .x (mixed),
            .y (h_out[i*8 +: 8])
        );
    end

endmodule

// File: rtl/hash_round_engine.sv
// Sequential hash engine: absorbs one byte per cycle and presents the digest
// on a valid/ready port. Define HASH_LEN_PAD_EN to absorb the byte count before OUT.
module hash_round_engine
    import hash_pkg::*;
#(
    parameter int N_LANES = 8,
    parameter int COUNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 msg_valid,
    output logic                 msg_ready,
    input  logic [7:0]           msg_data,
    input  logic                 msg_last,
    output logic                 dig_valid,
    input  logic                 dig_ready,
    output logic [N_LANES*8-1:0] digest,
    output logic                 busy,
    output logic [COUNT_W-1:0]   byte_count
);

    localparam int W = N_LANES * 8;

    hash_state_e  state;
    logic [W-1:0] h;
    logic [W-1:0] h_round;
    logic [W-1:0] iv;
    logic [7:0]   round_m;

    for (genvar i = 0; i < N_LANES; i++) begin : g_iv
        assign iv[i*8 +: 8] = hash_iv(i);
    end

`ifdef HASH_LEN_PAD_EN
    localparam int N_CB   = COUNT_W / 8;
    localparam int STEP_W = $clog2(N_CB) + 1;

    logic [STEP_W-1:0]  step;
    logic [COUNT_W-1:0] count_shifted;

    // The count is fed into the round least-significant byte first.
    assign count_shifted = byte_count >> {step, 3'b000};
    assign round_m       = (state == FINAL) ? count_shifted[7:0] : msg_data;
`else
    assign round_m = msg_data;
`endif

    hash_lane_round #(
        .N_LANES (N_LANES)
    ) u_round (
        .h_in  (h),
        .m     (round_m),
        .h_out (h_round)
    );

    assign msg_ready = (state == ABSORB);
    assign dig_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign digest    = h;

    // Clear only moves the FSM; hash state and count are left as they were.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            h          <= iv;
            byte_count <= '0;
`ifdef HASH_LEN_PAD_EN
            step       <= '0;
`endif
        end else if (clear) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        h          <= iv;
                        byte_count <= '0;
                        state      <= ABSORB;
                    end
                end
                ABSORB: begin
                    if (msg_valid) begin
                        h          <= h_round;
                        byte_count <= byte_count + COUNT_W'(1);
                        if (msg_last) begin
`ifdef HASH_LEN_PAD_EN
                            step  <= '0;
                            state <= FINAL;
`else
                            state <= OUT;
`endif
                        end
                    end
                end
`ifdef HASH_LEN_PAD_EN
                FINAL: begin
                    h    <= h_round;
                    step <= step + STEP_W'(1);
                    if (step == STEP_W'(N_CB - 1)) begin
                        state <= OUT;
                    end
                end
`endif
                OUT: begin
                    if (dig_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_round_engine.sv
// Directed bench for hash_round_engine: three instances (8, 2 and 32 lanes)
// share one stimulus stream and are checked against an independent model.
module tb_hash_round_engine;

`ifdef HASH_LEN_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clear = 1'b0;
    logic start = 1'b0;
    logic msg_valid = 1'b0;
    logic [7:0] msg_data = 8'h00;
    logic msg_last = 1'b0;
    logic dig_ready = 1'b0;

    logic msg_ready_8, dig_valid_8, busy_8;
    logic [63:0] digest_8;
    logic [15:0] count_8;
    logic msg_ready_2, dig_valid_2, busy_2;
    logic [15:0] digest_2;
    logic [7:0] count_2;
    logic msg_ready_32, dig_valid_32, busy_32;
    logic [255:0] digest_32;
    logic [15:0] count_32;

    int n_checks = 0;
    int n_fails = 0;
    logic [7:0] sbox_tab [256];
    logic [7:0] msg_q [$];

    always #5 clk = ~clk;

    hash_round_engine #(.N_LANES(8), .COUNT_W(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
        .msg_valid(msg_valid), .msg_ready(msg_ready_8), .msg_data(msg_data), .msg_last(msg_last),
        .dig_valid(dig_valid_8), .dig_ready(dig_ready), .digest(digest_8),
        .busy(busy_8), .byte_count(count_8)
    );

    hash_round_engine #(.N_LANES(2), .COUNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
        .msg_valid(msg_valid), .msg_ready(msg_ready_2), .msg_data(msg_data), .msg_last(msg_last),
        .dig_valid(dig_valid_2), .dig_ready(dig_ready), .digest(digest_2),
        .busy(busy_2), .byte_count(count_2)
    );

    hash_round_engine #(.N_LANES(32), .COUNT_W(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
        .msg_valid(msg_valid), .msg_ready(msg_ready_32), .msg_data(msg_data), .msg_last(msg_last),
        .dig_valid(dig_valid_32), .dig_ready(dig_ready), .digest(digest_32),
        .busy(busy_32), .byte_count(count_32)
    );

    // GF(2^8) multiply with the AES polynomial; the S-box is rebuilt from it.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rol(input logic [7:0] x, input int s);
        logic [7:0] r;
        r = (x << s) | (x >> (8 - s));
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_tab[a] = inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [255:0] model_round(input logic [255:0] h, input logic [7:0] m, input int n);
        logic [255:0] r;
        logic [7:0] x;
        r = '0;
        for (int i = 0; i < n; i++) begin
            x = h[((i + 1) % n)*8 +: 8] ^ m;
            r[i*8 +: 8] = sbox_tab[rol(x, i % 8)];
        end
        return r;
    endfunction

    function automatic logic [255:0] model_digest(input int n, input int cw, input int len, input bit pad);
        logic [255:0] h;
        logic [31:0] cnt;
        h = '0;
        for (int i = 0; i < n; i++) h[i*8 +: 8] = 8'h5A ^ 8'(i);
        for (int b = 0; b < len; b++) h = model_round(h, msg_q[b], n);
        if (pad) begin
            cnt = 32'(len) & ((32'd1 << cw) - 32'd1);
            for (int k = 0; k < cw / 8; k++) h = model_round(h, 8'(cnt >> (8 * k)), n);
        end
        return h;
    endfunction

    task automatic start_msg(input int len, input bit gaps, input bit fixed, input bit with_last);
        int g;
        msg_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (msg_ready_8 !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL msg_ready_after_start: got %b expected 1", msg_ready_8);
        end
        for (int b = 0; b < len; b++) begin
            g = gaps ? $urandom_range(0, 3) : 0;
            for (int j = 0; j < g; j++) begin
                msg_valid = 1'b0;
                msg_last  = 1'($urandom_range(0, 1));
                start     = 1'($urandom_range(0, 1));
                msg_data  = 8'($urandom);
                @(negedge clk);
            end
            start     = 1'b0;
            msg_data  = fixed ? 8'h5A : 8'($urandom);
            msg_valid = 1'b1;
            msg_last  = with_last && (b == len - 1);
            msg_q.push_back(msg_data);
            @(negedge clk);
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    // Called on the first falling edge after the last byte was accepted.
    task automatic check_digest(input string tag, input int len);
        int lat8, lat2, lat32, exp8_lat, exp2_lat;
        logic [255:0] e8, e2, e32;
        bit stable;
        lat8 = 0; lat2 = 0; lat32 = 0;
        exp8_lat = PAD ? 3 : 1;
        exp2_lat = PAD ? 2 : 1;
        e8  = model_digest(8, 16, len, PAD);
        e2  = model_digest(2, 8, len, PAD);
        e32 = model_digest(32, 16, len, PAD);
        for (int k = 1; k <= 6; k++) begin
            if (lat8 == 0 && dig_valid_8) lat8 = k;
            if (lat2 == 0 && dig_valid_2) lat2 = k;
            if (lat32 == 0 && dig_valid_32) lat32 = k;
            @(negedge clk);
        end
        n_checks += 3;
        if (lat8 != exp8_lat) begin n_fails++; $display("[TB] FAIL %s latency8: got %0d expected %0d", tag, lat8, exp8_lat); end
        if (lat2 != exp2_lat) begin n_fails++; $display("[TB] FAIL %s latency2: got %0d expected %0d", tag, lat2, exp2_lat); end
        if (lat32 != exp8_lat) begin n_fails++; $display("[TB] FAIL %s latency32: got %0d expected %0d", tag, lat32, exp8_lat); end
        n_checks += 6;
        if (digest_8 !== e8[63:0]) begin n_fails++; $display("[TB] FAIL %s digest8: got %h expected %h", tag, digest_8, e8[63:0]); end
        if (digest_2 !== e2[15:0]) begin n_fails++; $display("[TB] FAIL %s digest2: got %h expected %h", tag, digest_2, e2[15:0]); end
        if (digest_32 !== e32) begin n_fails++; $display("[TB] FAIL %s digest32: got %h expected %h", tag, digest_32, e32); end
        if (count_8 !== 16'(len)) begin n_fails++; $display("[TB] FAIL %s count8: got %0d expected %0d", tag, count_8, 16'(len)); end
        if (count_2 !== 8'(len)) begin n_fails++; $display("[TB] FAIL %s count2: got %0d expected %0d", tag, count_2, 8'(len)); end
        if (count_32 !== 16'(len)) begin n_fails++; $display("[TB] FAIL %s count32: got %0d expected %0d", tag, count_32, 16'(len)); end
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (digest_8 !== e8[63:0] || dig_valid_8 !== 1'b1) stable = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (!stable) begin n_fails++; $display("[TB] FAIL %s stall_stable: got unstable expected held %h", tag, e8[63:0]); end
        dig_ready = 1'b1;
        @(negedge clk);
        dig_ready = 1'b0;
        n_checks += 2;
        if (dig_valid_8 !== 1'b0 || dig_valid_2 !== 1'b0 || dig_valid_32 !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL %s ack_valid: got %b%b%b expected 000", tag, dig_valid_8, dig_valid_2, dig_valid_32);
        end
        if (busy_8 !== 1'b0) begin n_fails++; $display("[TB] FAIL %s ack_busy: got %b expected 0", tag, busy_8); end
    endtask

    task automatic test_reset();
        logic [255:0] iv8, iv32;
        msg_q.delete();
        iv8  = model_digest(8, 16, 0, 1'b0);
        iv32 = model_digest(32, 16, 0, 1'b0);
        #1 rst_n = 1'b0;
        @(negedge clk);
        n_checks += 5;
        if ({msg_ready_8, dig_valid_8, busy_8} !== 3'b000) begin n_fails++; $display("[TB] FAIL reset_flags: got %b expected 000", {msg_ready_8, dig_valid_8, busy_8}); end
        if (count_8 !== 16'd0) begin n_fails++; $display("[TB] FAIL reset_count: got %0d expected 0", count_8); end
        if (digest_8 !== iv8[63:0]) begin n_fails++; $display("[TB] FAIL reset_iv8: got %h expected %h", digest_8, iv8[63:0]); end
        if (digest_8 !== 64'h5d5c5f5e59585b5a) begin n_fails++; $display("[TB] FAIL reset_iv8_const: got %h expected 5d5c5f5e59585b5a", digest_8); end
        if (digest_32 !== iv32) begin n_fails++; $display("[TB] FAIL reset_iv32: got %h expected %h", digest_32, iv32); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        start_msg(1, 1'b0, 1'b1, 1'b1);
`ifndef HASH_LEN_PAD_EN
        n_checks += 2;
        if (digest_8[63:56] !== 8'h63) begin n_fails++; $display("[TB] FAIL single_lane7: got %h expected 63", digest_8[63:56]); end
        if (digest_8[7:0] !== 8'h7C) begin n_fails++; $display("[TB] FAIL single_lane0: got %h expected 7c", digest_8[7:0]); end
`endif
        check_digest("single", 1);
    endtask

    task automatic test_three_byte();
        start_msg(3, 1'b0, 1'b0, 1'b1);
        check_digest("three", 3);
    endtask

    task automatic test_stream_300();
        start_msg(300, 1'b1, 1'b0, 1'b1);
        check_digest("stream300", 300);
    endtask

    task automatic test_wrap_257();
        start_msg(257, 1'b0, 1'b0, 1'b1);
        check_digest("wrap257", 257);
    endtask

    task automatic test_clear_mid();
        logic [255:0] e8;
        start_msg(2, 1'b0, 1'b0, 1'b0);
        e8 = model_digest(8, 16, 2, 1'b0);
        msg_data  = 8'hC3;
        msg_valid = 1'b1;
        msg_last  = 1'b1;
        clear     = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        n_checks += 4;
        if (busy_8 !== 1'b0 || dig_valid_8 !== 1'b0) begin n_fails++; $display("[TB] FAIL clear_state: got busy=%b valid=%b expected 0 0", busy_8, dig_valid_8); end
        if (count_8 !== 16'd2) begin n_fails++; $display("[TB] FAIL clear_count: got %0d expected 2", count_8); end
        if (digest_8 !== e8[63:0]) begin n_fails++; $display("[TB] FAIL clear_hold: got %h expected %h", digest_8, e8[63:0]); end
        repeat (3) @(negedge clk);
        if (dig_valid_8 !== 1'b0) begin n_fails++; $display("[TB] FAIL clear_no_digest: got %b expected 0", dig_valid_8); end
        start_msg(4, 1'b0, 1'b0, 1'b1);
        check_digest("after_clear", 4);
    endtask

    task automatic test_reset_in_out();
        logic [255:0] iv8;
        int waited;
        start_msg(2, 1'b0, 1'b0, 1'b1);
        waited = 0;
        while (dig_valid_8 !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (dig_valid_8 !== 1'b1) begin n_fails++; $display("[TB] FAIL rst_reach_out: got %b expected 1", dig_valid_8); end
        msg_q.delete();
        iv8 = model_digest(8, 16, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (dig_valid_8 !== 1'b0 || busy_8 !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_async: got valid=%b busy=%b expected 0 0", dig_valid_8, busy_8); end
        if (digest_8 !== iv8[63:0]) begin n_fails++; $display("[TB] FAIL rst_iv: got %h expected %h", digest_8, iv8[63:0]); end
        if (count_8 !== 16'd0) begin n_fails++; $display("[TB] FAIL rst_count: got %0d expected 0", count_8); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        n_checks++;
        if (busy_8 !== 1'b0 || msg_ready_8 !== 1'b0) begin n_fails++; $display("[TB] FAIL start_clear: got busy=%b ready=%b expected 0 0", busy_8, msg_ready_8); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        build_sbox();
        test_reset();
        test_single_byte();
        test_three_byte();
        test_stream_300();
        test_wrap_257();
        test_clear_mid();
        test_reset_in_out();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
